// File: rtl/game2048_pkg.sv
// Shared types for the 2048 move path: direction encoding, encoder FSM states,
// idle button pattern and the fixed-priority direction picker.
package game2048_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ST_ARMED,
    ST_HELD
  } move_state_t;

  localparam logic [3:0] BTN_IDLE = 4'b1111;

  // Lowest pressed index wins: UP > DOWN > LEFT > RIGHT.
  function automatic dir_t prio_dir(input logic [3:0] btn_n);
    if (!btn_n[0]) return DIR_UP;
    if (!btn_n[1]) return DIR_DOWN;
    if (!btn_n[2]) return DIR_LEFT;
    return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small first-word-fall-through queue; write lands one edge after push, head visible immediately.
// A push while full is accepted only if a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits, so power-of-two depths wrap for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/move_cmd_encoder.sv
// Turns debounced active-low direction buttons into one queued move command per press.
// Press sampled at edge k -> cmd_valid after edge k; head held while !cmd_ready; full-queue presses dropped into sticky overflow.
// Optional hold-to-repeat behaviour is enabled by defining MOVE_CMD_AUTOREPEAT_EN.
module move_cmd_encoder
  import game2048_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
`ifdef MOVE_CMD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_n,
  output logic       cmd_valid,
  output dir_t       cmd_dir,
  input  logic       cmd_ready,
  output logic       overflow
);

  move_state_t state_q;
  move_state_t state_d;
  logic        push_req;
  dir_t        push_dir;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  fifo_dout;
  logic        rpt_fire;

`ifdef MOVE_CMD_AUTOREPEAT_EN
  dir_t        last_dir;
  logic [3:0]  btn_prev;
  logic [31:0] hold_cnt;
  logic        repeating;
  logic        hold_ok;

  // Counting needs a steady single button matching the last command issued.
  assign hold_ok  = (state_q == ST_HELD) && (btn_n == btn_prev) &&
                    ($countones(~btn_n) == 1) && (prio_dir(btn_n) == last_dir);
  assign rpt_fire = hold_ok &&
                    (hold_cnt == (repeating ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dir  <= DIR_UP;
      btn_prev  <= BTN_IDLE;
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else begin
      btn_prev <= btn_n;
      if (push_req) last_dir <= push_dir;
      if (!hold_ok) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (rpt_fire) begin
        hold_cnt  <= '0;
        repeating <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    push_dir = DIR_UP;
    case (state_q)
      ST_ARMED: begin
        if (btn_n != BTN_IDLE) begin
          push_req = 1'b1;
          push_dir = prio_dir(btn_n);
          state_d  = ST_HELD;
        end
      end
      default: begin
        if (btn_n == BTN_IDLE) begin
          state_d = ST_ARMED;
        end else if (rpt_fire) begin
          push_req = 1'b1;
          push_dir = prio_dir(btn_n);
        end
      end
    endcase
  end

  // Starting in HELD means a button held through reset must be released first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_HELD;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push_req && fifo_full && !cmd_ready) overflow <= 1'b1;
    end
  end

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (push_dir),
    .full  (fifo_full),
    .pop   (cmd_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;
  assign cmd_dir   = cmd_valid ? dir_t'(fifo_dout) : DIR_UP;

endmodule

// File: tb/tb_move_cmd_encoder.sv
// Directed bench: stimulus pushes expected commands into a scoreboard queue, a negedge monitor pops on every handshake.
module tb_move_cmd_encoder;

  logic       clk;
  logic       reset;
  logic [3:0] btn_n;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic       overflow;

  int n_vec;
  int n_bad;
  int sb[$];

  move_cmd_encoder #(
    .FIFO_DEPTH(2)
`ifdef MOVE_CMD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_n     (btn_n),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_ready (cmd_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int idle);
    btn_n = b;
    tick(hold);
    btn_n = 4'b1111;
    tick(idle);
  endtask

  task automatic do_reset(input logic [3:0] b);
    reset = 1'b0;
    btn_n = b;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  // Monitor: each accepted command must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_cmd", 1, 0);
      end else begin
        check("cmd_dir", int'(cmd_dir), sb.pop_front());
      end
    end
  end

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    btn_n     = 4'b1111;
    cmd_ready = 1'b1;
    tick(3);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_dir", int'(cmd_dir), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b1;
    tick(2);

    // 1: single UP press held 3 cycles -> exactly one command
    sb.push_back(0);
    press(4'b1110, 3, 6);
    check("t1_drained", sb.size(), 0);
    check("t1_idle_valid", int'(cmd_valid), 0);

    // 2: held through reset -> nothing until released and pressed again
    do_reset(4'b1110);
    tick(4);
    check("t2_no_cmd_while_held", int'(cmd_valid), 0);
    btn_n = 4'b1111;
    tick(2);
    sb.push_back(0);
    press(4'b1110, 2, 4);
    check("t2_drained", sb.size(), 0);

    // 3: LEFT+RIGHT picks LEFT; partial release does not re-arm
    sb.push_back(2);
    btn_n = 4'b0011;
    tick(3);
    btn_n = 4'b0111;
    tick(3);
    btn_n = 4'b1111;
    tick(3);
    check("t3_drained", sb.size(), 0);

    // 4: stalled consumer, third press overflows and is lost
    cmd_ready = 1'b0;
    sb.push_back(1);
    sb.push_back(3);
    press(4'b1101, 2, 2);
    press(4'b0111, 2, 2);
    check("t4_no_overflow_yet", int'(overflow), 0);
    press(4'b1110, 2, 2);
    check("t4_overflow", int'(overflow), 1);
    check("t4_head_valid", int'(cmd_valid), 1);
    check("t4_head_dir", int'(cmd_dir), 1);
    cmd_ready = 1'b1;
    tick(4);
    check("t4_drained", sb.size(), 0);
    check("t4_overflow_sticky", int'(overflow), 1);

    // 5: full queue with simultaneous pop and LEFT press -> no overflow
    do_reset(4'b1111);
    check("t5_overflow_cleared", int'(overflow), 0);
    tick(1);
    cmd_ready = 1'b0;
    sb.push_back(1);
    sb.push_back(3);
    press(4'b1101, 2, 2);
    press(4'b0111, 2, 2);
    sb.push_back(2);
    cmd_ready = 1'b1;
    press(4'b1011, 2, 4);
    check("t5_overflow", int'(overflow), 0);
    check("t5_drained", sb.size(), 0);

`ifdef MOVE_CMD_AUTOREPEAT_EN
    // 6: held DOWN for 20 cycles -> press, +8, +12, +16
    for (int i = 0; i < 4; i++) sb.push_back(1);
    press(4'b1101, 20, 6);
    check("t6_drained", sb.size(), 0);
    check("t6_overflow", int'(overflow), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
